// File: rtl/multi_port_regfile.sv
// multi_port_regfile: one synchronous write port, NUM_RD synchronous read ports,
// a hardware clear sweep that zeroes the array after reset or on clr_req,
// per-port read-valid flags and an optional hardwired zero register.
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding on
// same-address read-during-write; read-first when undefined).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_CLEAR  | sweep writes 0 to entry clr_cnt each cycle, busy=1, I/O ignored
// S_READY  | normal operation, busy=0, reads and writes accepted
module multi_port_regfile #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_req,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [BUS_WIDTH-1:0]           wr_data,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*BUS_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]              rd_valid,
    output logic                           busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;

    logic [BUS_WIDTH-1:0]    mem [DEPTH];

    logic                    wr_commit;
    logic                    mem_wen;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [BUS_WIDTH-1:0]    mem_wdata;
    logic [BUS_WIDTH-1:0]    rd_word [NUM_RD];

    // A write only lands when READY, not pre-empted by clr_req, and not aimed at the zero register
    assign wr_commit = (state == S_READY) && we && !clr_req &&
                       !((ZERO_REG != 0) && (wr_addr == '0));

    assign busy = (state == S_CLEAR);

    // State and sweep-pointer register; reset always starts a fresh sweep at entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state logic: sweep N entries then go READY; clr_req (re)starts the sweep
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_CLEAR: begin
                if (clr_req) begin
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt = S_READY;
                    end
                end
            end
            S_READY: begin
                if (clr_req) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = S_CLEAR;
                end
            end
            default: begin
                state_nxt   = S_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Array write-port mux: the sweep owns the port while clearing
    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == S_CLEAR) begin
            mem_wen   = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (wr_commit) begin
            mem_wen = 1'b1;
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep provides the zeroing
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Per-port read word: array contents, optional forwarding, zero-register override last
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_word[k] = mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr)) begin
                rd_word[k] = wr_data;
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                rd_word[k] = '0;
            end
        end
    end

    // Read registers: one-cycle latency, rd_valid pulses once per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if ((state == S_READY) && rd_en[k]) begin
                    rd_data[k*BUS_WIDTH +: BUS_WIDTH] <= rd_word[k];
                    rd_valid[k]                       <= 1'b1;
                end else begin
                    rd_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_port_regfile.sv
// tb_multi_port_regfile: directed vectors for the default configuration
// (8-bit data, 8 entries, two read ports, zero register enabled).
module tb_multi_port_regfile;

    localparam int BW = 8;
    localparam int AW = 3;
    localparam int NR = 2;

    logic             clk;
    logic             rst_n;
    logic             clr_req;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [BW-1:0]    wr_data;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*BW-1:0] rd_data;
    logic [NR-1:0]    rd_valid;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy;

    multi_port_regfile #(
        .BUS_WIDTH (BW),
        .ADDR_WIDTH(AW),
        .NUM_RD    (NR),
        .ZERO_REG  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until busy drops, bounded so a stuck sweep still reaches the summary
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_en   = 2'b11;
            rd_addr = {3'(7 - a), 3'(a)};
            step();
            check_val({tag, "_valid"}, 32'(rd_valid), 32'h3);
            check_val({tag, "_data"}, 32'(rd_data), 32'h0);
        end
        rd_en = 2'b00;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        we      = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;

        repeat (2) step();
        check_val("rst_rd_data", 32'(rd_data), 32'h0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;

        count_busy(n_busy);
        check_val("sweep_len", n_busy, 8);
        read_all_zero("init");

        // rd_en low: valid drops
        step();
        check_val("valid_drop", 32'(rd_valid), 32'h0);

        // write 3 <= A5, read on both ports
        we = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        step();
        we = 1'b0; rd_en = 2'b11; rd_addr = {3'd3, 3'd3};
        step();
        check_val("wr3_data", 32'(rd_data), 32'hA5A5);
        check_val("wr3_valid", 32'(rd_valid), 32'h3);

        // zero register: write FF to 0 dropped; port 0 holds A5
        we = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rd_en = 2'b00;
        step();
        check_val("zero_wr_novalid", 32'(rd_valid), 32'h0);
        we = 1'b0; rd_en = 2'b10; rd_addr = {3'd0, 3'd0};
        step();
        check_val("zero_rd_p1", 32'(rd_data[15:8]), 32'h00);
        check_val("zero_hold_p0", 32'(rd_data[7:0]), 32'hA5);
        check_val("zero_valid", 32'(rd_valid), 32'h2);

        // read-during-write on address 5
        we = 1'b1; wr_addr = 3'd5; wr_data = 8'h11; rd_en = 2'b00;
        step();
        wr_data = 8'h3C; rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
        step();
`ifdef REGFILE_BYPASS_EN
        check_val("rdw_same", 32'(rd_data[7:0]), 32'h3C);
`else
        check_val("rdw_same", 32'(rd_data[7:0]), 32'h11);
`endif
        we = 1'b0;
        step();
        check_val("rdw_after", 32'(rd_data[7:0]), 32'h3C);

        // independent ports on different addresses
        we = 1'b1; wr_addr = 3'd7; wr_data = 8'h5A; rd_en = 2'b00;
        step();
        wr_addr = 3'd1; wr_data = 8'hC3;
        step();
        we = 1'b0; rd_en = 2'b11; rd_addr = {3'd1, 3'd7};
        step();
        check_val("two_addr", 32'(rd_data), 32'hC35A);

        // clr_req with a same-cycle write: write dropped, sweep, reads blocked
        we = 1'b1; wr_addr = 3'd2; wr_data = 8'h55; rd_en = 2'b00;
        step();
        clr_req = 1'b1; wr_data = 8'h77;
        step();
        clr_req = 1'b0; we = 1'b0;
        check_val("clr_busy", 32'(busy), 32'h1);
        rd_en = 2'b11; rd_addr = {3'd2, 3'd2};
        n_busy = 0;
        while (busy && n_busy < 40) begin
            step();
            n_busy++;
            check_val("clr_novalid", 32'(rd_valid), 32'h0);
        end
        check_val("clr_len", n_busy, 8);
        step();
        check_val("clr_addr2_valid", 32'(rd_valid), 32'h3);
        check_val("clr_addr2_data", 32'(rd_data), 32'h0);
        rd_en = 2'b00;

        // reset in the middle of a sweep restarts it from entry 0
        we = 1'b1; wr_addr = 3'd4; wr_data = 8'h99;
        step();
        we = 1'b0; rd_en = 2'b01; rd_addr = {3'd0, 3'd4};
        step();
        check_val("pre_rst_rd4", 32'(rd_data[7:0]), 32'h99);
        rd_en = 2'b00; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #2;
        check_val("mid_rst_data", 32'(rd_data), 32'h0);
        check_val("mid_rst_valid", 32'(rd_valid), 32'h0);
        check_val("mid_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        count_busy(n_busy);
        check_val("mid_rst_len", n_busy, 8);
        read_all_zero("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
